mdio_master: RTL and testbench

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_master.sv | 167 ++++++++++++++++
 tb/tb_mdio_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// MDIO management master. It serialises one 32-bit frame (ST/OP/PHYAD/REGAD/
// TA/data) after an optional preamble of ones. Each bit is 2*CLK_DIV clk
// cycles long, with mdc low for the first half and high for the second half.
// For read frames (OP=2'b10) the pad is released from bit 17 onward. In that
// case data bits 15..0 are sampled on the mdc rising edge.
module mdio_master #(
  parameter int CLK_DIV      = 2,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        transmit_we,
  input  logic [31:0] transmit_data_in,
  output logic        transmit_ready,
  input  logic        receive_re,
  output logic [15:0] receive_data,
  output logic        receive_valid,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]        PRE_LAST = 5'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

  typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME, DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        frame_q, frame_d;
  logic [4:0]         bit_q, bit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               mdc_q, mdc_d;
  logic               out_q, out_d;
  logic               oe_q, oe_d;
  logic [15:0]        shift_q, shift_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               is_read;
  logic               half_end;
  logic               load_bit;

  assign is_read        = (frame_q[29:28] == 2'b10);
  assign half_end       = (div_q == DIV_LAST);
  assign transmit_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign mdc            = mdc_q;
  assign mdio_out       = out_q;
  assign mdio_oe        = oe_q;
  assign receive_data   = rdata_q;
  assign receive_valid  = rvalid_q;

  // Next-state logic: bit timing, frame sequencing and pad drive for the next bit.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    frame_d  = frame_q;
    bit_d    = bit_q;
    div_d    = div_q;
    mdc_d    = mdc_q;
    out_d    = out_q;
    oe_d     = oe_q;
    shift_d  = shift_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    load_bit = 1'b0;

    // An acknowledge that lands on the completion cycle of a read loses to the set.
    if (receive_re && !(state_q == DONE && is_read)) rvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        mdc_d = 1'b0;
        oe_d  = 1'b0;
        out_d = 1'b1;
        if (transmit_we) begin
          frame_d  = transmit_data_in;
          load_bit = 1'b1;
          if (PREAMBLE_LEN == 0) begin
            state_d = FRAME;
            bit_d   = 5'd31;
          end else begin
            state_d = PREAMBLE;
            bit_d   = PRE_LAST;
          end
        end
      end
      PREAMBLE, FRAME: begin
        if (!half_end) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          mdc_d = ~mdc_q;
          if (!mdc_q) begin
            // mdc rising: sample the PHY during the data field of a read.
            if (state_q == FRAME && is_read && bit_q <= 5'd15)
              shift_d = {shift_q[14:0], mdio_in};
          end else if (bit_q != 5'd0) begin
            bit_d    = bit_q - 5'd1;
            load_bit = 1'b1;
          end else if (state_q == PREAMBLE) begin
            state_d  = FRAME;
            bit_d    = 5'd31;
            load_bit = 1'b1;
          end else begin
            state_d = DONE;
            oe_d    = 1'b0;
            out_d   = 1'b1;
            if (is_read) begin
              rdata_d  = shift_q;
              rvalid_d = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        mdc_d   = 1'b0;
        oe_d    = 1'b0;
        out_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Pad drive for the bit that starts now (mdc entering its low phase).
    if (load_bit) begin
      oe_d  = 1'b1;
      out_d = 1'b1;
      if (state_d == FRAME) begin
        if (frame_d[29:28] == 2'b10 && bit_d <= 5'd17) oe_d = 1'b0;
        else                                           out_d = frame_d[bit_d];
      end
    end
  end

  // State registers with asynchronous reset to the idle pad state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      mdc_q    <= 1'b0;
      out_q    <= 1'b1;
      oe_q     <= 1'b0;
      shift_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      frame_q  <= frame_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      mdc_q    <= mdc_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master. A frame-level model tracks the cycles
// since accept and derives the expected pins from bit position arithmetic.
// It also plays the PHY on mdio_in. A second instance runs at CLK_DIV=1 with
// no preamble.
module tb_mdio_master;

  localparam int D1 = 2;
  localparam int P1 = 32;
  localparam int N2 = (P1 + 32) * 2 * D1;   // cycles of serial activity, 256

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        transmit_we = 1'b0;
  logic [31:0] transmit_data_in = '0;
  logic        transmit_ready;
  logic        receive_re = 1'b0;
  logic [15:0] receive_data;
  logic        receive_valid;
  logic        busy, mdc, mdio_out, mdio_oe;
  logic        mdio_in = 1'b0;

  logic        we2 = 1'b0;
  logic [31:0] data2 = '0;
  logic        ready2, busy2, mdc2, out2, oe2, rvalid2;
  logic [15:0] rdata2;
  logic        rre2 = 1'b0;
  logic        min2 = 1'b0;

  int errors = 0;
  int checks = 0;

  // frame-level model state
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [31:0] m_frame = '0;
  logic [15:0] m_phy = '0;
  logic [15:0] m_rdata = '0;
  logic        m_rvalid = 1'b0;
  logic [15:0] next_phy = '0;

  mdio_master #(.CLK_DIV(D1), .PREAMBLE_LEN(P1)) dut (
    .clk(clk), .reset(reset),
    .transmit_we(transmit_we), .transmit_data_in(transmit_data_in),
    .transmit_ready(transmit_ready),
    .receive_re(receive_re), .receive_data(receive_data), .receive_valid(receive_valid),
    .busy(busy), .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe), .mdio_in(mdio_in)
  );

  mdio_master #(.CLK_DIV(1), .PREAMBLE_LEN(0)) dut_fast (
    .clk(clk), .reset(reset),
    .transmit_we(we2), .transmit_data_in(data2), .transmit_ready(ready2),
    .receive_re(rre2), .receive_data(rdata2), .receive_valid(rvalid2),
    .busy(busy2), .mdc(mdc2), .mdio_out(out2), .mdio_oe(oe2), .mdio_in(min2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {mdc, oe, out} k cycles after the accept edge.
  function automatic logic [2:0] exp_pins(input int k, input logic [31:0] f, input int d, input int p);
    int  bitpos, idx;
    logic m, oe;
    if (k >= (p + 32) * 2 * d) return 3'b001;
    bitpos = k / (2 * d);
    m      = ((k % (2 * d)) >= d);
    if (bitpos < p) return {m, 2'b11};
    idx = 31 - (bitpos - p);
    oe  = !(f[29:28] == 2'b10 && idx <= 17);
    return {m, oe, oe ? f[idx] : 1'b1};
  endfunction

  // Model update at each active edge, then the PHY drives mdio_in for the new cycle.
  always @(posedge clk) begin
    bit is_rd;
    int bp, idx;
    if (!reset) begin
      m_active = 1'b0;
      m_k      = 0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
    end else begin
      is_rd = (m_frame[29:28] == 2'b10);
      if (receive_re && !(m_active && m_k == N2 && is_rd)) m_rvalid = 1'b0;
      if (m_active) begin
        m_k++;
        if (m_k == N2 && is_rd) begin
          m_rvalid = 1'b1;
          m_rdata  = m_phy;
        end
        if (m_k > N2) m_active = 1'b0;
      end else if (transmit_we) begin
        m_active = 1'b1;
        m_k      = 0;
        m_frame  = transmit_data_in;
        m_phy    = next_phy;
      end
    end
    #1;
    mdio_in = 1'($urandom % 2);
    if (m_active && m_k < N2 && (m_k / (2 * D1)) >= P1) begin
      bp  = m_k / (2 * D1);
      idx = 31 - (bp - P1);
      if (m_frame[29:28] == 2'b10 && idx <= 15) mdio_in = m_phy[idx];
    end
  end

  // Compare process: every out-of-reset cycle, away from the active edge.
  always @(negedge clk) begin
    logic [2:0] p;
    if (reset) begin
      p = m_active ? exp_pins(m_k, m_frame, D1, P1) : 3'b001;
      check("ctrl", {46'd0, transmit_ready, busy}, {46'd0, !m_active, m_active});
      check("pins", {46'd0, mdc, mdio_oe}, {46'd0, p[2], p[1]});
      if (p[1]) check("mdio_out", {47'd0, mdio_out}, {47'd0, p[0]});
      if (!m_active) check("idle_out", {47'd0, mdio_out}, 48'd1);
      check("rx", {31'd0, receive_valid, receive_data}, {31'd0, m_rvalid, m_rdata});
    end
  end

  task automatic send(input logic [31:0] w, input logic [15:0] phy);
    int n = 0;
    while (!transmit_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!transmit_ready) begin
      errors++;
      $display("FAIL ready_timeout: transmit_ready still 0 after %0d cycles", n);
    end
    next_phy         = phy;
    transmit_data_in = w;
    transmit_we      = 1'b1;
    @(posedge clk); #1;
    transmit_we      = 1'b0;
  endtask

  // Runs one frame to its DONE cycle, returns the bits seen at each mdc rise.
  task automatic run_frame(input logic [31:0] w, input logic [15:0] phy, input int stray_k,
                           input bit done_re, output logic [63:0] stream,
                           output int busy_cnt, output int oe_rises);
    logic prev = 1'b0;
    send(w, phy);
    stream = '0; busy_cnt = 0; oe_rises = 0;
    for (int k = 0; k <= N2; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (mdc && !prev) begin
        stream = {stream[62:0], mdio_out};
        if (mdio_oe) oe_rises++;
      end
      prev = mdc;
      if (k == stray_k) begin
        check("ready_midframe", {47'd0, transmit_ready}, 48'd0);
        transmit_we      = 1'b1;
        transmit_data_in = ~w;
      end else if (k == stray_k + 1) begin
        transmit_we = 1'b0;
      end
      if (k == N2 && done_re) receive_re = 1'b1;
    end
  endtask

  initial begin
    logic [63:0] s;
    logic [31:0] w, fw;
    logic [2:0]  p;
    int bc, orises, fb;
    logic [31:0] fs;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {44'd0, transmit_ready, busy, mdc, mdio_oe}, {44'd0, 4'b1000});
    check("rst_out", {47'd0, mdio_out}, 48'd1);
    check("rst_rx", {31'd0, receive_valid, receive_data}, 48'd0);

    // write at defaults, released reset then accepted on the very next edge,
    // with an ignored write request mid-frame
    @(posedge clk); #1;
    reset = 1'b1;
    run_frame(32'h5082BEEF, 16'h0000, 100, 1'b0, s, bc, orises);
    check("wr_stream", s[47:0], {16'hFFFF, 32'h5082BEEF});
    check("wr_stream_hi", {32'd0, s[63:48]}, {32'd0, 16'hFFFF});
    check("wr_busy", 48'(bc), 48'd257);
    check("wr_oe", 48'(orises), 48'd64);
    @(posedge clk); #1;
    check("wr_rvalid", {47'd0, receive_valid}, 48'd0);

    // read with PHY returning A55A, acknowledge on DONE and one cycle later
    run_frame(32'h60820000, 16'hA55A, -1, 1'b1, s, bc, orises);
    check("rd_done", {31'd0, receive_valid, receive_data}, {31'd0, 1'b1, 16'hA55A});
    check("rd_oe_rises", 48'(orises), 48'd46);
    check("rd_busy", 48'(bc), 48'd257);
    @(negedge clk);
    check("rd_set_wins", {47'd0, receive_valid}, 48'd1);
    @(negedge clk);
    check("rd_cleared", {47'd0, receive_valid}, 48'd0);
    receive_re = 1'b0;

    // fast instance: CLK_DIV=1, no preamble
    fw = 32'hC3A51E96;
    @(posedge clk); #1;
    data2 = fw; we2 = 1'b1;
    @(posedge clk); #1;
    we2 = 1'b0;
    fs = '0; fb = 0;
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk);
      p = exp_pins(k, fw, 1, 0);
      check("fast_pins", {46'd0, mdc2, oe2}, {46'd0, p[2], p[1]});
      if (busy2) fb++;
      if (mdc2) fs = {fs[30:0], out2};
    end
    check("fast_stream", {16'd0, fs}, {16'd0, 32'hC3A51E96});
    check("fast_busy", 48'(fb), 48'd65);
    @(negedge clk);
    check("fast_ready", {46'd0, ready2, busy2}, {46'd0, 2'b10});

    // randomized traffic against the model
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk); #1;
      w = $urandom;
      if ($urandom % 2 == 0) w[29:28] = 2'b10;
      transmit_data_in = w;
      transmit_we      = ($urandom % 8 == 0);
      receive_re       = ($urandom % 16 == 0);
      next_phy         = 16'($urandom);
    end
    @(posedge clk); #1;
    transmit_we = 1'b0;
    receive_re  = 1'b0;

    // reset at frame bit 10, then a clean write
    send(32'h5AC31234, 16'h0000);
    repeat (4 * (P1 + 21) + 2) @(negedge clk);
    check("pre_abort_busy", {46'd0, busy, mdio_oe}, {46'd0, 2'b11});
    #2 reset = 1'b0;
    #1;
    check("abort", {45'd0, mdc, mdio_oe, busy}, 48'd0);
    check("abort_ready", {47'd0, transmit_ready}, 48'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    run_frame(32'h9F00C0DE, 16'h0000, -1, 1'b0, s, bc, orises);
    check("post_rst_stream", s[47:0], {16'hFFFF, 32'h9F00C0DE});
    check("post_rst_busy", 48'(bc), 48'd257);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
